// File: rtl/sample_stream_player.sv
// Paced ROM sample player: fetches one sample every RATE_DIV cycles into a small FIFO,
// words leave the cycle after the push whenever audio_out_allowed is high; a full FIFO drops the new sample.

module sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         not_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign not_empty = (count != '0);
  assign dout      = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && not_empty;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module sample_stream_player #(
  parameter int ADDR_W     = 20,
  parameter int SAMPLE_W   = 6,
  parameter int OUT_W      = 32,
  parameter int RATE_DIV   = 1042,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_mode,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                enable,
  input  logic [2:0]          volume,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [OUT_W-1:0]    left_channel_audio_out,
  output logic [OUT_W-1:0]    right_channel_audio_out,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

  typedef enum logic [2:0] {IDLE, PACE, FETCH, WAIT, PUSH} state_t;

  state_t              state;
  logic [DIV_W-1:0]    divider;
  logic [DIV_W-1:0]    div_next;
  logic [ADDR_W-1:0]   win_start;
  logic [ADDR_W-1:0]   win_end;
  logic                loop_q;
  logic                fifo_flush;
  logic                fifo_push;
  logic                fifo_full;
  logic                fifo_not_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic [OUT_W-1:0]    word;

  // start/stop in a PUSH cycle discard the sample being written.
  assign fifo_push  = (state == PUSH) && !start && !stop;
  assign fifo_flush = stop || (start && state != IDLE);
  assign div_next   = (divider == DIV_LAST) ? '0 : divider + 1'b1;

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk  (CLOCK_50),
    .arst_n    (reset_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .pop       (write_audio_out),
    .din       (rom_q),
    .dout      (fifo_head),
    .full      (fifo_full),
    .not_empty (fifo_not_empty)
  );

  assign write_audio_out         = fifo_not_empty && audio_out_allowed;
  assign word                    = enable ? (OUT_W'(fifo_head) << volume) : '0;
  assign left_channel_audio_out  = word;
  assign right_channel_audio_out = word;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      divider   <= '0;
      rom_addr  <= '0;
      win_start <= '0;
      win_end   <= '0;
      loop_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        win_start <= start_addr;
        win_end   <= end_addr;
        loop_q    <= loop_mode;
        rom_addr  <= start_addr;
        divider   <= '0;
        overflow  <= 1'b0;
        if (start_addr > end_addr) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= PACE;
          busy  <= 1'b1;
        end
      end else begin
        // The divider free-runs while active so the fetch period stays exactly RATE_DIV.
        if (state != IDLE) divider <= div_next;
        case (state)
          IDLE: state <= IDLE;
          PACE: if (divider == DIV_LAST) state <= FETCH;
          FETCH: state <= (ROM_LAT > 1) ? WAIT : PUSH;
          WAIT: state <= PUSH;
          PUSH: begin
            if (fifo_full && !write_audio_out) overflow <= 1'b1;
            if (rom_addr != win_end) begin
              rom_addr <= rom_addr + 1'b1;
              state    <= PACE;
            end else if (loop_q) begin
              rom_addr <= win_start;
              state    <= PACE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sample_stream_player.sv
// Randomised bench for sample_stream_player against a timing/queue reference model.
module tb_sample_stream_player;
  localparam int ADDR_W   = 8;
  localparam int SAMPLE_W = 6;
  localparam int OUT_W    = 32;
  localparam int RATE_DIV = 8;
  localparam int ROM_LAT  = 1;
  localparam int DEPTH    = 4;

  logic                CLOCK_50 = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                loop_mode = 1'b0;
  logic [ADDR_W-1:0]   start_addr = '0;
  logic [ADDR_W-1:0]   end_addr = '0;
  logic                enable = 1'b1;
  logic [2:0]          volume = '0;
  logic [ADDR_W-1:0]   rom_addr;
  logic [SAMPLE_W-1:0] rom_q = '0;
  logic                audio_out_allowed = 1'b1;
  logic                write_audio_out;
  logic [OUT_W-1:0]    left_channel_audio_out;
  logic [OUT_W-1:0]    right_channel_audio_out;
  logic                busy;
  logic                done;
  logic                overflow;

  logic [SAMPLE_W-1:0] rom [256];

  sample_stream_player #(
    .ADDR_W     (ADDR_W),
    .SAMPLE_W   (SAMPLE_W),
    .OUT_W      (OUT_W),
    .RATE_DIV   (RATE_DIV),
    .ROM_LAT    (ROM_LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .reset_n                 (reset_n),
    .start                   (start),
    .stop                    (stop),
    .loop_mode               (loop_mode),
    .start_addr              (start_addr),
    .end_addr                (end_addr),
    .enable                  (enable),
    .volume                  (volume),
    .rom_addr                (rom_addr),
    .rom_q                   (rom_q),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .busy                    (busy),
    .done                    (done),
    .overflow                (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) rom_q <= rom[rom_addr];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of buffered samples plus playback timing derived from the start edge.
  logic [SAMPLE_W-1:0] mq[$];
  bit m_active = 0;
  bit m_done = 0;
  bit m_ovf = 0;
  bit m_loop = 0;
  int m_start = 0;
  int m_len = 1;
  int t0 = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_done = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge();
    int e;
    int k;
    int a;
    m_done = 0;
    if (mq.size() > 0 && audio_out_allowed) void'(mq.pop_front());
    if (stop) begin
      m_active = 0;
      mq.delete();
    end else if (start) begin
      if (m_active) mq.delete();
      m_ovf = 0;
      if (start_addr > end_addr) begin
        m_active = 0;
        m_done = 1;
      end else begin
        m_active = 1;
        t0 = cyc;
        m_start = int'(start_addr);
        m_len = int'(end_addr) - int'(start_addr) + 1;
        m_loop = loop_mode;
      end
    end else if (m_active) begin
      // Sample k lands in the FIFO RATE_DIV*(k+1) + ROM_LAT + 1 edges after the start edge.
      e = cyc - t0 - (ROM_LAT + 1);
      if (e >= RATE_DIV && e % RATE_DIV == 0) begin
        k = e / RATE_DIV - 1;
        a = m_start + (m_loop ? k % m_len : k);
        if (mq.size() < DEPTH) mq.push_back(rom[a]);
        else m_ovf = 1;
        if (!m_loop && k == m_len - 1) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    logic        exp_wr;
    logic [31:0] exp_word;
    #1;
    exp_wr = (mq.size() > 0) && audio_out_allowed;
    check_val("write", write_audio_out, exp_wr);
    if (exp_wr) begin
      exp_word = enable ? (32'(mq[0]) << volume) : 32'd0;
      check_val("left", left_channel_audio_out, exp_word);
      check_val("right", right_channel_audio_out, exp_word);
    end
    check_val("busy", busy, m_active);
    check_val("done", done, m_done);
    check_val("overflow", overflow, m_ovf);
    model_edge();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start(input int sa, input int ea, input bit lp);
    start_addr = ADDR_W'(sa);
    end_addr = ADDR_W'(ea);
    loop_mode = lp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_write"}, write_audio_out, 0);
    check_val({tag, "_left"}, left_channel_audio_out, 0);
    check_val({tag, "_right"}, right_channel_audio_out, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_overflow"}, overflow, 0);
    check_val({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  int allow_pct = 80;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = SAMPLE_W'($urandom);
    for (int i = 0; i < 16; i++) rom[i] = SAMPLE_W'(i + 1);
    rom[20] = 6'h3F;

    #12;
    check_all_zero("reset");
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    // One-shot window 0..3
    pulse_start(0, 3, 0);
    run(45);

    // Looping window, twelve fetches, then abort
    pulse_start(0, 3, 1);
    run(12 * RATE_DIV + 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(5);

    // Backpressure: six fetches into a four-entry FIFO, then drain
    audio_out_allowed = 1'b0;
    pulse_start(0, 5, 0);
    run(55);
    audio_out_allowed = 1'b1;
    run(8);

    // Maximum sample at full volume, then muted
    volume = 3'd7;
    pulse_start(20, 20, 1);
    run(30);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    volume = 3'd0;
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Restart mid-window, then an inverted window
    audio_out_allowed = 1'b0;
    pulse_start(0, 7, 1);
    run(2 * RATE_DIV + 5);
    audio_out_allowed = 1'b1;
    pulse_start(10, 11, 0);
    run(30);
    pulse_start(5, 3, 0);
    run(3);

    // Asynchronous reset with buffered samples waiting
    audio_out_allowed = 1'b0;
    pulse_start(0, 7, 1);
    run(22);
    audio_out_allowed = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    run(30);

    // Random soak
    repeat (3000) begin
      if ($urandom % 64 == 0) allow_pct = $urandom_range(0, 100);
      audio_out_allowed = ($urandom % 100) < allow_pct;
      enable = ($urandom % 8) != 0;
      volume = 3'($urandom);
      loop_mode = $urandom % 2;
      start_addr = ADDR_W'($urandom_range(0, 240));
      if ($urandom % 8 == 0 && start_addr > 0) end_addr = start_addr - 1'b1;
      else end_addr = start_addr + ADDR_W'($urandom_range(0, 7));
      start = ($urandom % 50) == 0;
      stop = ($urandom % 250) == 0;
      step();
    end
    start = 1'b0;
    stop = 1'b0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
